sdram_burst_sched: RTL and testbench

SDRAM_BURST_SCHED -- requirements
Module: sdram_burst_sched

---
 rtl/sdram_burst_sched.sv | 267 ++++++++++++++++++++++++++
 tb/tb_sdram_burst_sched.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_sched.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_burst_sched
//  Description : Burst scheduler between two user-side 16-bit FIFOs and an
//                SDRAM controller. Full bursts of BURST_LEN words are moved
//                from the write FIFO to SDRAM and back into the read FIFO,
//                with linear 23-bit write/read pointers mapped onto
//                bank/row/column. Reads win over writes when both are ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_burst_sched #(
    parameter int FIFO_DEPTH = 16,
    parameter int BURST_LEN  = 8
) (
    input  logic        clk,
    input  logic        rst,
    // user write side
    input  logic        wr_req,
    input  logic [15:0] wr_din,
    output logic        wr_full,
    output logic        wr_ovf,
    // user read side
    input  logic        rd_req,
    output logic [15:0] rd_dout,
    output logic        rd_empty,
    // controller command / data
    output logic        ctl_wr_en,
    output logic        ctl_rd_en,
    output logic [1:0]  ctl_bank,
    output logic [12:0] ctl_row,
    output logic [8:0]  ctl_col,
    output logic [15:0] ctl_wr_data,
    input  logic        ctl_wrdata_vld,
    input  logic        ctl_wdata_done,
    input  logic        ctl_rddata_vld,
    input  logic [15:0] ctl_rd_data,
    input  logic        ctl_rdata_done
);

    localparam int          c_PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          c_CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_BURST = c_CNT_W'(BURST_LEN);
    localparam logic [22:0] c_ADDR_STEP = 23'(BURST_LEN);
    localparam logic [20:0] c_OCC_LIMIT = 21'h100000;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_REQ   = 3'd1,
        WR_BURST = 3'd2,
        RD_REQ   = 3'd3,
        RD_BURST = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // write FIFO
    logic [15:0]        r_wf_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wf_wptr;
    logic [c_PTR_W-1:0] r_wf_rptr;
    logic [c_CNT_W-1:0] r_wf_cnt;
    logic               w_wf_push;
    logic               w_wf_pop;
    logic               w_wf_pop_en;

    // read FIFO
    logic [15:0]        r_rf_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_rf_wptr;
    logic [c_PTR_W-1:0] r_rf_rptr;
    logic [c_CNT_W-1:0] r_rf_cnt;
    logic               w_rf_push;
    logic               w_rf_pop;
    logic               w_rf_push_en;
    logic               w_rf_full;

    // SDRAM side bookkeeping
    logic [22:0]        r_wa;
    logic [22:0]        r_ra;
    logic [20:0]        r_occ;
    logic [22:0]        r_addr;
    logic               r_ctl_wr_en;
    logic               r_ctl_rd_en;
    logic               w_wr_done;
    logic               w_rd_done;
    logic               w_rd_elig;
    logic               w_wr_elig;
    logic               w_issue_wr;
    logic               w_issue_rd;

    // ------------------------------------------------------------------------
    // FIFO handshakes. A push into a full write FIFO is dropped even when a
    // pop frees a slot in the same cycle, so full is judged on the old count.
    // ------------------------------------------------------------------------
    assign wr_full     = (r_wf_cnt == c_CNT_FULL);
    assign wr_ovf      = wr_req & wr_full;
    assign w_wf_push   = wr_req & ~wr_full;
    assign w_wf_pop    = w_wf_pop_en & (r_wf_cnt != '0);
    assign ctl_wr_data = r_wf_mem[r_wf_rptr];

    assign rd_empty    = (r_rf_cnt == '0);
    assign w_rf_full   = (r_rf_cnt == c_CNT_FULL);
    assign w_rf_pop    = rd_req & ~rd_empty;
    assign w_rf_push   = w_rf_push_en & ~w_rf_full;
    assign rd_dout     = r_rf_mem[r_rf_rptr];

    // Read needs a stored burst and room for a whole burst in the read FIFO,
    // which reserves the space so the controller can never overflow it.
    assign w_rd_elig = (r_occ != '0) && ((c_CNT_FULL - r_rf_cnt) >= c_CNT_BURST);
    assign w_wr_elig = (r_wf_cnt >= c_CNT_BURST) && (r_occ < c_OCC_LIMIT);

    assign w_issue_wr = (r_state == IDLE) && (w_state_next == WR_REQ);
    assign w_issue_rd = (r_state == IDLE) && (w_state_next == RD_REQ);

    // Write FIFO storage: capture the user word on an accepted push
    always_ff @(posedge clk) begin
        if (w_wf_push) begin
            r_wf_mem[r_wf_wptr] <= wr_din;
        end
    end

    // Write FIFO pointers and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wf_wptr <= '0;
            r_wf_rptr <= '0;
            r_wf_cnt  <= '0;
        end else begin
            if (w_wf_push) begin
                r_wf_wptr <= (r_wf_wptr == c_PTR_LAST) ? '0 : r_wf_wptr + 1'b1;
            end
            if (w_wf_pop) begin
                r_wf_rptr <= (r_wf_rptr == c_PTR_LAST) ? '0 : r_wf_rptr + 1'b1;
            end
            case ({w_wf_push, w_wf_pop})
                2'b10:   r_wf_cnt <= r_wf_cnt + 1'b1;
                2'b01:   r_wf_cnt <= r_wf_cnt - 1'b1;
                default: r_wf_cnt <= r_wf_cnt;
            endcase
        end
    end

    // Read FIFO storage: capture controller data during a read burst
    always_ff @(posedge clk) begin
        if (w_rf_push) begin
            r_rf_mem[r_rf_wptr] <= ctl_rd_data;
        end
    end

    // Read FIFO pointers and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_wptr <= '0;
            r_rf_rptr <= '0;
            r_rf_cnt  <= '0;
        end else begin
            if (w_rf_push) begin
                r_rf_wptr <= (r_rf_wptr == c_PTR_LAST) ? '0 : r_rf_wptr + 1'b1;
            end
            if (w_rf_pop) begin
                r_rf_rptr <= (r_rf_rptr == c_PTR_LAST) ? '0 : r_rf_rptr + 1'b1;
            end
            case ({w_rf_push, w_rf_pop})
                2'b10:   r_rf_cnt <= r_rf_cnt + 1'b1;
                2'b01:   r_rf_cnt <= r_rf_cnt - 1'b1;
                default: r_rf_cnt <= r_rf_cnt;
            endcase
        end
    end

    // Scheduler state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Scheduler next state and burst-phase data strobes
    always_comb begin
        w_state_next = r_state;
        w_wf_pop_en  = 1'b0;
        w_rf_push_en = 1'b0;
        w_wr_done    = 1'b0;
        w_rd_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rd_elig) begin
                    w_state_next = RD_REQ;
                end else if (w_wr_elig) begin
                    w_state_next = WR_REQ;
                end
            end
            WR_REQ: begin
                w_state_next = WR_BURST;
            end
            WR_BURST: begin
                w_wf_pop_en = ctl_wrdata_vld;
                if (ctl_wdata_done) begin
                    w_wr_done    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            RD_REQ: begin
                w_state_next = RD_BURST;
            end
            RD_BURST: begin
                w_rf_push_en = ctl_rddata_vld;
                if (ctl_rdata_done) begin
                    w_rd_done    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Linear SDRAM pointers and burst occupancy, updated on burst completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wa  <= '0;
            r_ra  <= '0;
            r_occ <= '0;
        end else begin
            if (w_wr_done) begin
                r_wa <= r_wa + c_ADDR_STEP;
            end
            if (w_rd_done) begin
                r_ra <= r_ra + c_ADDR_STEP;
            end
            if (w_wr_done) begin
                r_occ <= r_occ + 1'b1;
            end else if (w_rd_done) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

    // Registered command strobes; the address latches on issue and holds
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctl_wr_en <= 1'b0;
            r_ctl_rd_en <= 1'b0;
            r_addr      <= '0;
        end else begin
            r_ctl_wr_en <= w_issue_wr;
            r_ctl_rd_en <= w_issue_rd;
            if (w_issue_wr) begin
                r_addr <= r_wa;
            end else if (w_issue_rd) begin
                r_addr <= r_ra;
            end
        end
    end

    assign ctl_wr_en = r_ctl_wr_en;
    assign ctl_rd_en = r_ctl_rd_en;
    assign ctl_bank  = r_addr[22:21];
    assign ctl_row   = {1'b0, r_addr[20:9]};
    assign ctl_col   = r_addr[8:0];

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_burst_sched
//  Description : Self-checking bench for sdram_burst_sched. A behavioural
//                model (queues and counters) predicts every output each
//                cycle; a reactive SDRAM controller model stores and returns
//                burst data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_burst_sched;

    localparam int FIFO_DEPTH = 16;
    localparam int BURST_LEN  = 8;
    localparam int unsigned ADDR_MASK = 32'h7FFFFF;
    localparam int P_IDLE = 0, P_WC = 1, P_WB = 2, P_RC = 3, P_RB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req;
    logic [15:0] wr_din;
    logic        wr_full;
    logic        wr_ovf;
    logic        rd_req;
    logic [15:0] rd_dout;
    logic        rd_empty;
    logic        ctl_wr_en;
    logic        ctl_rd_en;
    logic [1:0]  ctl_bank;
    logic [12:0] ctl_row;
    logic [8:0]  ctl_col;
    logic [15:0] ctl_wr_data;
    logic        ctl_wrdata_vld;
    logic        ctl_wdata_done;
    logic        ctl_rddata_vld;
    logic [15:0] ctl_rd_data;
    logic        ctl_rdata_done;

    always #5 clk = ~clk;

    sdram_burst_sched #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .BURST_LEN  (BURST_LEN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_req         (wr_req),
        .wr_din         (wr_din),
        .wr_full        (wr_full),
        .wr_ovf         (wr_ovf),
        .rd_req         (rd_req),
        .rd_dout        (rd_dout),
        .rd_empty       (rd_empty),
        .ctl_wr_en      (ctl_wr_en),
        .ctl_rd_en      (ctl_rd_en),
        .ctl_bank       (ctl_bank),
        .ctl_row        (ctl_row),
        .ctl_col        (ctl_col),
        .ctl_wr_data    (ctl_wr_data),
        .ctl_wrdata_vld (ctl_wrdata_vld),
        .ctl_wdata_done (ctl_wdata_done),
        .ctl_rddata_vld (ctl_rddata_vld),
        .ctl_rd_data    (ctl_rd_data),
        .ctl_rdata_done (ctl_rdata_done)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: write FIFO contents, end-to-end data stream (oldest
    // accepted word first), read FIFO fill level, pointers, burst count.
    logic [15:0] m_wq [$];
    logic [15:0] m_stream [$];
    int          m_rcnt;
    int          m_occ;
    int unsigned m_wa;
    int unsigned m_ra;
    int unsigned m_addr;
    int          m_ph;

    // Controller model state
    logic [15:0] c_mem [int unsigned];
    int          c_mode;
    int          c_cnt;
    int unsigned c_base;
    bit          stall;
    bit          stray;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_wq.delete();
        m_stream.delete();
        m_rcnt = 0;
        m_occ  = 0;
        m_wa   = 0;
        m_ra   = 0;
        m_addr = 0;
        m_ph   = P_IDLE;
    endtask

    // Monitor: compare outputs with the model mid-cycle, then advance the
    // model by the inputs that the coming rising edge will sample.
    initial begin : monitor
        bit push_ok, wpop, rpush, rpop, rd_elig, wr_elig;
        m_reset();
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("wr_full", 32'(wr_full), 32'(m_wq.size() == FIFO_DEPTH));
            chk("rd_empty", 32'(rd_empty), 32'(m_rcnt == 0));
            chk("wr_ovf", 32'(wr_ovf), 32'(wr_req && m_wq.size() == FIFO_DEPTH));
            chk("ctl_wr_en", 32'(ctl_wr_en), 32'(m_ph == P_WC));
            chk("ctl_rd_en", 32'(ctl_rd_en), 32'(m_ph == P_RC));
            chk("ctl_bank", 32'(ctl_bank), (m_addr >> 21) & 32'h3);
            chk("ctl_row", 32'(ctl_row), (m_addr >> 9) & 32'hFFF);
            chk("ctl_col", 32'(ctl_col), m_addr & 32'h1FF);
            if (m_rcnt > 0 && m_stream.size() > 0)
                chk("rd_dout", 32'(rd_dout), 32'(m_stream[0]));
            if (m_ph == P_WB && ctl_wrdata_vld && m_wq.size() > 0)
                chk("ctl_wr_data", 32'(ctl_wr_data), 32'(m_wq[0]));

            if (rst) begin
                m_reset();
            end else begin
                push_ok = wr_req && (m_wq.size() < FIFO_DEPTH);
                wpop    = (m_ph == P_WB) && ctl_wrdata_vld && (m_wq.size() > 0);
                rpush   = (m_ph == P_RB) && ctl_rddata_vld && (m_rcnt < FIFO_DEPTH);
                rpop    = rd_req && (m_rcnt > 0);
                rd_elig = (m_occ > 0) && (FIFO_DEPTH - m_rcnt >= BURST_LEN);
                wr_elig = (m_wq.size() >= BURST_LEN) && (m_occ < (1 << 20));
                case (m_ph)
                    P_IDLE: begin
                        if (rd_elig) begin
                            m_ph = P_RC; m_addr = m_ra;
                        end else if (wr_elig) begin
                            m_ph = P_WC; m_addr = m_wa;
                        end
                    end
                    P_WC: m_ph = P_WB;
                    P_RC: m_ph = P_RB;
                    P_WB: if (ctl_wdata_done) begin
                        m_ph = P_IDLE; m_wa = (m_wa + BURST_LEN) & ADDR_MASK; m_occ++;
                    end
                    P_RB: if (ctl_rdata_done) begin
                        m_ph = P_IDLE; m_ra = (m_ra + BURST_LEN) & ADDR_MASK; m_occ--;
                    end
                    default: m_ph = P_IDLE;
                endcase
                if (wpop) void'(m_wq.pop_front());
                if (push_ok) begin
                    m_wq.push_back(wr_din);
                    m_stream.push_back(wr_din);
                end
                if (rpush) m_rcnt++;
                if (rpop) begin
                    m_rcnt--;
                    void'(m_stream.pop_front());
                end
            end
        end
    end

    // SDRAM controller model: reacts to command strobes, stores write bursts
    // and replays them on reads, with random gaps and optional stray strobes.
    initial begin : controller
        c_mode = 0; c_cnt = 0; c_base = 0;
        ctl_wrdata_vld = 0; ctl_wdata_done = 0; ctl_rddata_vld = 0;
        ctl_rdata_done = 0; ctl_rd_data = 0;
        forever begin
            @(posedge clk); #2;
            ctl_wrdata_vld = 0; ctl_wdata_done = 0;
            ctl_rddata_vld = 0; ctl_rdata_done = 0;
            ctl_rd_data = 16'($urandom);
            if (rst) begin
                c_mode = 0; c_cnt = 0;
            end else if (c_mode == 0) begin
                if (ctl_wr_en || ctl_rd_en) begin
                    c_mode = ctl_wr_en ? 1 : 2;
                    c_cnt  = 0;
                    c_base = int'({ctl_bank, ctl_row[11:0], ctl_col});
                end else if (stray) begin
                    ctl_wrdata_vld = ($urandom_range(0, 3) == 0);
                    ctl_rddata_vld = ($urandom_range(0, 3) == 0);
                end
            end else if (c_mode == 1) begin
                if (stray) ctl_rddata_vld = ($urandom_range(0, 3) == 0);
                if (!stall && $urandom_range(0, 3) != 0) begin
                    if (c_cnt < BURST_LEN) begin
                        ctl_wrdata_vld = 1;
                        c_mem[(c_base + c_cnt) & ADDR_MASK] = ctl_wr_data;
                        c_cnt++;
                    end else begin
                        ctl_wdata_done = 1;
                        c_mode = 0;
                    end
                end
            end else begin
                if (stray) ctl_wrdata_vld = ($urandom_range(0, 3) == 0);
                if (!stall && $urandom_range(0, 3) != 0) begin
                    if (c_cnt < BURST_LEN) begin
                        ctl_rddata_vld = 1;
                        ctl_rd_data = c_mem.exists((c_base + c_cnt) & ADDR_MASK) ?
                                      c_mem[(c_base + c_cnt) & ADDR_MASK] : 16'hDEAD;
                        c_cnt++;
                    end else begin
                        ctl_rdata_done = 1;
                        c_mode = 0;
                    end
                end
            end
        end
    end

    task automatic push_words(input int n, input logic [15:0] base, input int step);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            wr_req = 1; wr_din = base + 16'(step * i); rd_req = 0;
        end
        @(posedge clk); #1;
        wr_req = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            wr_req = 0; rd_req = 0;
        end
    endtask

    task automatic pop_words(input int n, input int budget);
        int got = 0;
        int t = 0;
        while (got < n && t < budget) begin
            @(posedge clk); #1;
            t++;
            wr_req = 0;
            rd_req = !rd_empty;
            if (!rd_empty) got++;
        end
        @(posedge clk); #1;
        rd_req = 0;
        chk("pops_done", 32'(got), 32'(n));
    endtask

    task automatic reset_cycle();
        @(posedge clk); #1;
        wr_req = 0; rd_req = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin : stimulus
        int t;
        rst = 1; wr_req = 0; wr_din = 0; rd_req = 0; stall = 0; stray = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        idle_cycles(3);

        // Single burst round trip: words 0x0000..0x000E at address 0
        push_words(8, 16'h0000, 2);
        pop_words(8, 300);
        idle_cycles(4);

        // Sixteen words: read of first burst must precede second write
        push_words(16, 16'h1000, 1);
        idle_cycles(60);
        pop_words(16, 400);

        // Overflow: controller stalled, 17 pushes, 17th dropped
        stall = 1;
        push_words(17, 16'h2000, 1);
        idle_cycles(3);
        stall = 0;
        pop_words(16, 400);
        idle_cycles(4);

        // Reset after three data beats of a write burst
        push_words(8, 16'h3000, 1);
        t = 0;
        while (!(c_mode == 1 && c_cnt >= 3) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("mid_burst_reached", 32'(c_mode == 1 && c_cnt >= 3), 32'd1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        push_words(7, 16'h3100, 1);
        idle_cycles(20);
        push_words(1, 16'h3107, 1);
        pop_words(8, 300);

        // Pointer wrap at the top of the address space
        reset_cycle();
        @(negedge clk); #1;
        dut.r_wa <= 23'h7FFFF8;
        dut.r_ra <= 23'h7FFFF8;
        m_wa = 32'h7FFFF8;
        m_ra = 32'h7FFFF8;
        push_words(16, 16'h4000, 1);
        pop_words(16, 400);

        // Random traffic with stray strobes, stalls and occasional reset
        stray = 1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            wr_req = 1'($urandom_range(0, 1));
            wr_din = 16'($urandom);
            rd_req = ($urandom_range(0, 2) != 0);
            rst    = ($urandom_range(0, 799) == 0);
            if (i % 25 == 0) stall = ($urandom_range(0, 3) == 0);
        end
        @(posedge clk); #1;
        rst = 0; wr_req = 0; stall = 0; stray = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            rd_req = 1;
        end
        @(posedge clk); #1;
        rd_req = 0;
        idle_cycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
